// File: rtl/fifo_read_streamer.sv
// Read-side streamer for the async FIFO: pops words (1-cycle read latency) into a
// 2-entry skid buffer and presents them as a framed valid/ready stream.
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] entry_q [2];
  logic                  head_q;
  logic                  tail_q;
  logic [1:0]            occ_q;
  logic                  infl_q;
  logic [BW-1:0]         bcnt_q;
  logic [CNT_WIDTH-1:0]  wcnt_q;
  logic                  pop;
  logic [1:0]            space;

  function automatic logic [BW-1:0] beat_inc(input logic [BW-1:0] b);
    return (b == BEAT_LAST) ? '0 : b + BW'(1);
  endfunction

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = entry_q[head_q];
  assign m_last     = m_valid & (bcnt_q == BEAT_LAST);
  assign word_count = wcnt_q;

  // occ + infl never exceeds 2, so space stays in 0..2; a same-cycle pop frees a slot
  always_comb begin
    pop       = m_valid & m_ready;
    space     = 2'd2 - occ_q - {1'b0, infl_q} + {1'b0, pop};
    fifo_r_en = rrst_n & enable & ~fifo_empty & (space != 2'd0);
  end

  // capture of the word read last cycle, and stream-side pop bookkeeping
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      infl_q     <= 1'b0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
    end else begin
      infl_q <= fifo_r_en;
      occ_q  <= occ_q + {1'b0, infl_q} - {1'b0, pop};
      if (infl_q) begin
        entry_q[tail_q] <= fifo_data_out;
        tail_q          <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
        bcnt_q <= beat_inc(bcnt_q);
        wcnt_q <= wcnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: behavioural FIFO source, scoreboard queue of
// expected beats, a timing vector table and hand-written corner-case sequences.
module tb_fifo_read_streamer;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_r_en;
  logic [7:0] fifo_data_out;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [15:0] word_count;

  logic       enable2;
  logic       fifo_r_en2;
  logic [7:0] d2;
  logic       m_valid2;
  logic [7:0] m_data2;
  logic       m_last2;
  logic [3:0] word_count2;

  always #5 rclk = ~rclk;

  fifo_read_streamer #(.DATA_WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(16)) u_dut (
    .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_r_en(fifo_r_en), .fifo_data_out(fifo_data_out), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .word_count(word_count)
  );

  fifo_read_streamer #(.DATA_WIDTH(8), .PKT_LEN(1), .CNT_WIDTH(4)) u_dut2 (
    .rclk(rclk), .rrst_n(rrst_n), .enable(enable2), .fifo_empty(1'b0),
    .fifo_r_en(fifo_r_en2), .fifo_data_out(d2), .m_valid(m_valid2),
    .m_ready(1'b1), .m_data(m_data2), .m_last(m_last2), .word_count(word_count2)
  );

  // behavioural FIFO: registered read data, one cycle after fifo_r_en
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rclk) begin
    if (fifo_r_en) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // incrementing source for the PKT_LEN=1 / CNT_WIDTH=4 instance
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) d2 <= 8'h00;
    else if (fifo_r_en2) d2 <= d2 + 8'h01;
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t exp_q[$];
  int   tb_bcnt = 0;
  logic [15:0] exp_wc = 16'h0;
  logic [7:0]  exp2 = 8'h01;
  int          beats2 = 0;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       exp_ren;
    logic       exp_vld;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 1;
    exp_q.push_back({d, (tb_bcnt == 3)});
    tb_bcnt = (tb_bcnt + 1) % 4;
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      step();
      c++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // scoreboard / protocol monitor for the main instance
  initial begin
    logic       stall_q = 1'b0;
    logic [7:0] hold_d  = 8'h0;
    logic       hold_l  = 1'b0;
    exp_t       e;
    forever begin
      @(negedge rclk);
      if (!rrst_n) begin
        exp_wc  = 16'h0;
        stall_q = 1'b0;
      end else begin
        if (fifo_empty) chk("underflow_guard", fifo_r_en, 0);
        if (!m_valid) chk("last_when_idle", m_last, 0);
        if (stall_q) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, hold_d);
          chk("hold_last", m_last, hold_l);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_beat", m_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e.d);
            chk("beat_last", m_last, e.l);
            exp_wc = exp_wc + 16'h1;
          end
        end
        stall_q = m_valid && !m_ready;
        hold_d  = m_data;
        hold_l  = m_last;
      end
    end
  end

  // monitor for the PKT_LEN=1 instance: every beat is last, data in order
  initial begin
    forever begin
      @(negedge rclk);
      if (!rrst_n) begin
        exp2 = 8'h01;
      end else if (m_valid2) begin
        chk("p1_last", m_last2, 1);
        chk("p1_data", m_data2, exp2);
        exp2   = exp2 + 8'h01;
        beats2 = beats2 + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    rrst_n  = 1'b0;
    enable  = 1'b1;
    enable2 = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h11 * (i + 1));
    step();
    step();
    chk("rst_r_en", fifo_r_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_wc", word_count, 0);

    // first packet: latency and back-to-back delivery
    rrst_n = 1'b1;
    for (int j = 0; j < 7; j++) begin
      if (j > 0) step();
      enable  = vecs[j].en;
      m_ready = vecs[j].rdy;
      #1;
      chk($sformatf("vec%0d_r_en", j), fifo_r_en, vecs[j].exp_ren);
      chk($sformatf("vec%0d_valid", j), m_valid, vecs[j].exp_vld);
      if (vecs[j].exp_vld) chk($sformatf("vec%0d_data", j), m_data, vecs[j].exp_data);
      chk($sformatf("vec%0d_last", j), m_last, vecs[j].exp_last);
    end
    step();
    chk("pkt1_wc", word_count, 4);

    // backpressure: only two reads fit while stalled
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h11 * (i + 1));
    #1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (fifo_r_en) n++;
      step();
    end
    chk("bp_reads", n, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'h11);
    m_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_nogap%0d", i), m_valid, 1);
      step();
    end
    wait_drain(20, "bp_drain");
    chk("bp_wc", word_count, 12);

    // alternating ready
    for (int i = 0; i < 12; i++) push_word(8'hA0 + 8'(i));
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      m_ready = ~m_ready;
      step();
      n++;
    end
    chk("toggle_drain", exp_q.size(), 0);
    m_ready = 1'b1;
    step();
    chk("toggle_wc", word_count, 24);

    // enable dropped right after the third read issues
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hD1 + 8'(i));
    step();
    enable = 1'b1;
    step();
    step();
    step();
    enable = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("en_off_r_en%0d", i), fifo_r_en, 0);
      step();
    end
    chk("en_off_inflight_out", exp_q.size(), 1);
    enable = 1'b1;
    wait_drain(10, "en_resume_drain");
    chk("en_wc", word_count, 28);

    // asynchronous reset with words buffered and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hE1 + 8'(i));
    step();
    step();
    #1;
    chk("pre_rst_valid", m_valid, 1);
    rrst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_wc", word_count, 0);
    chk("async_rst_r_en", fifo_r_en, 0);
    exp_q.delete();
    wr_ptr  = rd_ptr;
    tb_bcnt = 0;
    @(negedge rclk);
    step();
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'hC1 + 8'(i));
    wait_drain(20, "post_rst_drain");
    step();
    chk("post_rst_wc", word_count, 4);

    // PKT_LEN=1, CNT_WIDTH=4: 17 beats wrap the counter to 1
    enable2 = 1'b1;
    for (int i = 0; i < 17; i++) step();
    enable2 = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("p1_beats", beats2, 17);
    chk("p1_wc_wrap", word_count2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_streamer.md
Name: fifo_read_streamer

Overview:
- Read-side consumer for the team's asynchronous FIFO; lives entirely in the read clock domain.
- Pops words from the FIFO read port (empty / r_en / data_out, 1-cycle registered read latency) and presents them as a valid/ready stream with packet framing.
- Holds a 2-entry skid buffer so that downstream backpressure never loses a word and steady-state throughput is 1 word/cycle.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- PKT_LEN, 4, beats per packet; m_last asserted on beat PKT_LEN-1; legal range 1..65535.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rrst_n  in  1  asynchronous active-low reset.
- enable  in  1  permits issuing new FIFO reads.
- fifo_empty  in  1  FIFO empty flag (read-domain synchronised).
- fifo_r_en  out  1  FIFO read strobe; combinational.
- fifo_data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_r_en.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  stream data, head of skid buffer.
- m_last  out  1  final beat of packet.
- word_count  out  CNT_WIDTH  total accepted beats since reset; wraps.

Behaviour:
- Reset (async assert, sync release): fifo_r_en=0, m_valid=0, m_data=0, m_last=0, word_count=0; buffer occupancy, in-flight flag and beat counter all 0.
- Skid buffer: 2 entries, circular, with head/tail pointers and occupancy count occ in 0..2. m_valid = (occ!=0). m_data = entry[head].
- Handshake: pop = m_valid & m_ready. m_data and m_last hold stable while m_valid=1 and m_ready=0.
- In-flight: infl is a register equal to the previous cycle's fifo_r_en. When infl=1, fifo_data_out is written to entry[tail] at the current edge.
- Space rule: space = 2 - occ - infl + pop.
  - fifo_r_en = enable & !fifo_empty & (space >= 1).
  - fifo_r_en never asserts while fifo_empty=1; this is a FIFO underflow guard.
- Occupancy update: occ_next = occ + infl - pop. Simultaneous write and pop leaves occ unchanged; occ never exceeds 2.
- Latency: fifo_r_en in cycle N -> word captured at end of N+1 -> m_valid in N+2 (if buffer was empty). Steady state with m_ready=1 gives 1 beat/cycle.
- Ordering: words leave in exactly the order read; no drops, no duplicates.
- Beat counter bcnt (0..PKT_LEN-1):
  - increments on pop; wraps to 0 after PKT_LEN-1.
  - m_last = m_valid & (bcnt == PKT_LEN-1).
  - PKT_LEN=1 gives m_last on every beat.
- word_count increments by 1 on each pop; wraps modulo 2^CNT_WIDTH.
- enable deassert: no new reads; the in-flight word and buffered words still drain normally. Re-assert resumes with no gap in framing; bcnt is not reset.
- fifo_empty rising while a read is in flight: the in-flight word is still captured; empty only blocks future reads.
- m_ready low with buffer full: fifo_r_en=0 until a pop frees space; space counts that same-cycle pop.
- Reset mid-operation: buffered and in-flight data discarded; framing restarts at bcnt=0.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44, enable=1, m_ready=1 -> fifo_r_en high 4 consecutive cycles; m_data 0x11..0x44 on consecutive cycles, first m_valid 2 cycles after first fifo_r_en; m_last only on 0x44; word_count=4.
- 8 words queued, m_ready held 0 -> exactly 2 reads issued, occ=2, m_data stays 0x11. Then m_ready=1 -> remaining 6 delivered in order, no gaps after restart, m_last on beats 4 and 8.
- m_ready toggling 1010... over 12 words -> all 12 in order, no loss; fifo_r_en never asserted with fifo_empty=1.
- enable dropped the cycle after a read issues -> that word still appears on m_data; no further fifo_r_en until enable returns; bcnt continues (e.g. beat 3 then beat 4 with m_last).
- rrst_n pulsed low with occ=2 and infl=1 -> m_valid=0 immediately (asynchronously), word_count=0. After release, the next delivered word has bcnt=0.
- CNT_WIDTH=4, 17 beats delivered -> word_count reads 1 (wrap); PKT_LEN=1 -> m_last on every beat.
